capture_cell_scheduler: RTL and testbench
=========================================

// Module: capture_cell_scheduler
// PURPOSE
//  Shares one bank of dual-edge capture cells (rising phase stores d, falling phase stores ~d) among NREQ requesters.
//  Arbitrates round-robin and drives the bank's data, enable and phase lines.
//  Waits the bank's capture latency, samples its output and checks it against the expected value for the requested phase.
//  Returns one response per accepted request. Sits between test/config agents and the capture-cell datapath.
// PARAMETERS
//  NREQ     4  number of requesters (>=2)
//  WIDTH    8  capture word width
//  CAP_LAT  2  cycles from cap_en pulse until cap_q is valid (>=1)
//  IDW      $clog2(NREQ)  requester-id width (derived, not overridable)
// PORTS
//  clk        in   1           single clock; all state updates on posedge clk
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   NREQ        per-requester request
//  req_data   in   NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//  req_inv    in   NREQ        1 = falling (inverting) phase, 0 = rising (pass) phase
//  req_ready  out  NREQ        one-hot accept, 1-cycle pulse
//  cap_d      out  WIDTH       data to capture bank
//  cap_en     out  1           capture strobe, 1-cycle pulse
//  cap_phase  out  1           phase select to bank (0 rise, 1 fall)
//  cap_q      in   WIDTH       capture bank output
//  rsp_valid  out  1           response pulse, 1 cycle, no backpressure
//  rsp_id     out  IDW         id of the requester being answered
//  rsp_data   out  WIDTH       cap_q sampled at check time
//  rsp_err    out  1           1 = cap_q != expected
//  busy       out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset (any cycle, including mid-operation)
//   - State -> IDLE; RR pointer -> NREQ-1, so requester 0 wins first.
//   - All outputs 0. An in-flight request is dropped with no response.
//  FSM: IDLE -> DRIVE -> WAIT -> RESP -> IDLE
//   IDLE
//    - If any req_valid is set, the RR winner g gets req_ready[g]=1 in this same cycle (combinational from req_valid and the pointer).
//    - Latch data, inv and id; pointer <= g; go to DRIVE.
//    - With no request, stay in IDLE.
//   DRIVE (1 cycle): cap_en=1; cap_d=latched data; cap_phase=latched inv.
//   WAIT (CAP_LAT cycles)
//    - cap_en=0; cap_d and cap_phase held stable; down-counter reloaded on DRIVE entry.
//    - In the last WAIT cycle, register: rsp_data <= cap_q; rsp_err <= (cap_q != (inv ? ~data : data)).
//   RESP (1 cycle): rsp_valid=1 with rsp_id, rsp_data, rsp_err; go to IDLE.
//  Latency
//   - Accept at T: cap_en at T+1, rsp_valid at T+2+CAP_LAT.
//   - Next accept no earlier than T+3+CAP_LAT.
//  Arbitration
//   - Search starts at pointer+1 and wraps modulo NREQ.
//   - NREQ-1 wraps to 0.
//   - A requester holding req_valid continuously is served at most once per NREQ grants when others are requesting.
//  Boundaries
//   - req_ready is 0 in every state except IDLE; requests arriving then wait and are not lost while req_valid stays high.
//   - Dropping req_valid after acceptance has no effect.
//   - req_data/req_inv changes after acceptance are ignored.
//   - cap_d, cap_phase and rsp_* hold their last values when idle; only the pulses (cap_en, rsp_valid, req_ready) return to 0.
//   - The compare is the full WIDTH bits, with no masking.
// STRUCTURE
//  - Package capture_sched_pkg: state enum {IDLE, DRIVE, WAIT, RESP}; localparams PHASE_RISE=1'b0, PHASE_FALL=1'b1.
//  - Sub-module rr_arbiter #(N): inputs req and last-grant pointer; outputs one-hot gnt, encoded idx, any.
//  - The latency counter is CAP_LAT-sized and lives inline.
// TESTING
//  1. Reset mid-WAIT (rst high 1 cycle) -> next cycle all outputs 0, busy=0; no rsp_valid ever for that request.
//  2. req_valid=4'b0001, data=8'hA5, inv=0, cap_q model=pass -> cap_en at T+1, cap_phase=0; rsp at T+4 with id=0, data=A5, err=0.
//  3. req_valid=4'b0100, data=8'h3C, inv=1, bank model inverts -> cap_phase=1; rsp id=2, data=C3, err=0.
//  4. Same as 3 but bank model forced to pass-through -> rsp_data=3C, rsp_err=1.
//  5. req_valid=4'b1111 held for 8 grants -> grant order 0,1,2,3,0,1,2,3; each req_ready one cycle; spacing exactly 5 cycles.
//  6. req_valid=4'b1010 with req 3 dropping req_valid after accept -> req 3 still gets rsp; next grant goes to 1.

Source files
------------

// File: rtl/capture_sched_pkg.sv
// Shared types and constants for the capture-cell scheduler slice.
package capture_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic PHASE_RISE = 1'b0;
    localparam logic PHASE_FALL = 1'b1;

endpackage

// File: rtl/capture_cell_scheduler_rr_arbiter.sv
// Round-robin arbiter: search begins one past the last grant and wraps modulo N.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/capture_cell_scheduler.sv
// Time-shares one dual-edge capture bank among NREQ requesters and checks
// each capture against the phase-dependent expected word.
module capture_cell_scheduler
    import capture_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CAP_LAT = 2,
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]         req_inv,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        cap_d,
    output logic                    cap_en,
    output logic                    cap_phase,
    input  logic [WIDTH-1:0]        cap_q,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int unsigned CNTW = (CAP_LAT > 1) ? $clog2(CAP_LAT) : 1;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic             gnt_any;
    logic             accept;
    logic             sample;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] sel_data;
    logic             sel_inv;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] data_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (gnt_any) state_next = DRIVE;
            DRIVE:   state_next = WAIT;
            WAIT:    if (cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode; req_ready is the only combinational output
    always_comb begin
        accept    = (state == IDLE) && gnt_any && !rst;
        sample    = (state == WAIT) && (cnt == '0);
        req_ready = accept ? gnt : '0;
        sel_data  = data_arr[gnt_idx];
        sel_inv   = req_inv[gnt_idx];
        expected  = (cap_phase == PHASE_FALL) ? ~cap_d : cap_d;
    end

    // Registered bank drive, latency counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= IDW'(NREQ - 1);
            id_q      <= '0;
            cnt       <= '0;
            cap_d     <= '0;
            cap_en    <= 1'b0;
            cap_phase <= PHASE_RISE;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cap_en    <= accept;
            rsp_valid <= sample;
            busy      <= (state_next != IDLE);
            if (accept) begin
                cap_d     <= sel_data;
                cap_phase <= sel_inv;
                id_q      <= gnt_idx;
                ptr       <= gnt_idx;
                cnt       <= CNTW'(CAP_LAT - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNTW'(1);
            end
            if (sample) begin
                rsp_data <= cap_q;
                rsp_err  <= (cap_q != expected);
                rsp_id   <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_capture_cell_scheduler.sv
// Directed bench for capture_cell_scheduler with a behavioural capture bank.
module tb_capture_cell_scheduler;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned CAP_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]   req_inv = '0;
    logic [NREQ-1:0]   req_ready;
    logic [WIDTH-1:0]  cap_d;
    logic              cap_en;
    logic              cap_phase;
    logic [WIDTH-1:0]  cap_q;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_err;
    logic              busy;

    int tests = 0;
    int fails = 0;

    // Bank model: honours phase unless forced to pass-through
    logic             bank_pass = 1'b0;
    logic [WIDTH-1:0] bank = '0;
    always_ff @(posedge clk)
        if (cap_en) bank <= (!bank_pass && cap_phase) ? ~cap_d : cap_d;
    assign cap_q = bank;

    always #5 clk = ~clk;

    capture_cell_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .CAP_LAT(CAP_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_inv   (req_inv),
        .req_ready (req_ready),
        .cap_d     (cap_d),
        .cap_en    (cap_en),
        .cap_phase (cap_phase),
        .cap_q     (cap_q),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] valid;
        logic [7:0] data;
        logic       inv;
        logic       pass;
        int         id;
        logic [7:0] rdata;
        logic       err;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full single-requester transaction checked cycle by cycle
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bank_pass = v.pass;
        req_valid = v.valid;
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = (i == v.id) ? v.data : ~v.data;
            req_inv[i]         = (i == v.id) ? v.inv  : ~v.inv;
        end
        #1;
        chk("accept_ready", 32'(req_ready), 32'(v.valid));
        chk("accept_busy", 32'(busy), 0);
        @(negedge clk);
        req_valid = '0;
        req_data  = ~req_data;
        req_inv   = ~req_inv;
        #1;
        chk("drive_en", 32'(cap_en), 1);
        chk("drive_d", 32'(cap_d), 32'(v.data));
        chk("drive_phase", 32'(cap_phase), 32'(v.inv));
        chk("drive_busy", 32'(busy), 1);
        @(negedge clk); #1;
        chk("wait_en_low", 32'(cap_en), 0);
        chk("wait_d_held", 32'({cap_phase, cap_d}), 32'({v.inv, v.data}));
        @(negedge clk); #1;
        chk("wait_no_rsp", 32'(rsp_valid), 0);
        @(negedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_id", 32'(rsp_id), 32'(v.id));
        chk("rsp_data", 32'(rsp_data), 32'(v.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(v.err));
        @(negedge clk); #1;
        chk("idle_pulse_low", 32'({rsp_valid, busy, cap_en}), 0);
        chk("idle_hold", 32'({rsp_err, rsp_data, cap_phase, cap_d}),
            32'({v.err, v.rdata, v.inv, v.data}));
    endtask

    initial begin
        int gcount;
        int rcount;
        int last_c;
        int quiet;
        int order [8];
        order = '{0, 1, 2, 3, 0, 1, 2, 3};

        vt[0] = '{4'b0001, 8'hA5, 1'b0, 1'b1, 0, 8'hA5, 1'b0};
        vt[1] = '{4'b0100, 8'h3C, 1'b1, 1'b0, 2, 8'hC3, 1'b0};
        vt[2] = '{4'b0100, 8'h3C, 1'b1, 1'b1, 2, 8'h3C, 1'b1};
        vt[3] = '{4'b1000, 8'hFF, 1'b1, 1'b0, 3, 8'h00, 1'b0};
        vt[4] = '{4'b0010, 8'h00, 1'b0, 1'b1, 1, 8'h00, 1'b0};
        vt[5] = '{4'b0001, 8'h5A, 1'b1, 1'b1, 0, 8'h5A, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("por_outputs", 32'({req_ready, cap_en, cap_phase, rsp_valid, rsp_id, rsp_err, busy}), 0);
        chk("por_data", 32'({cap_d, rsp_data}), 0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Reset during WAIT drops the request silently
        @(negedge clk);
        bank_pass = 1'b0;
        req_data  = {4{8'h77}};
        req_inv   = 4'b0000;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ctrl", 32'({req_ready, cap_en, cap_phase, rsp_valid, rsp_id, rsp_err, busy}), 0);
        chk("midrst_data", 32'({cap_d, rsp_data}), 0);
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (rsp_valid) quiet++;
        end
        chk("midrst_no_rsp", 32'(quiet), 0);

        // All four held: strict rotation, one grant per 3+CAP_LAT cycles
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(17 * (i + 1));
        req_inv   = 4'b0000;
        req_valid = 4'b1111;
        gcount = 0;
        rcount = 0;
        last_c = 0;
        for (int c = 0; c < 44; c++) begin
            if (gcount == 8) req_valid = '0;
            #1;
            if (req_ready != '0) begin
                chk("rr_onehot", 32'($countones(req_ready)), 1);
                chk("rr_order", 32'(idx_of(req_ready)), 32'(order[gcount]));
                if (gcount > 0) chk("rr_spacing", 32'(c - last_c), 5);
                last_c = c;
                gcount++;
            end
            if (rsp_valid && rcount < 8) begin
                chk("rr_rsp_id", 32'(rsp_id), 32'(order[rcount]));
                chk("rr_rsp_data", 32'(rsp_data), 32'(17 * (order[rcount] + 1)));
                rcount++;
            end
            @(negedge clk);
        end
        chk("rr_grants", 32'(gcount), 8);
        chk("rr_rsps", 32'(rcount), 8);

        // Requester 3 drops after acceptance but is still answered
        do_reset();
        req_data  = {8'hD3, 8'h00, 8'hB1, 8'h00};
        req_inv   = 4'b0000;
        req_valid = 4'b1010;
        #1;
        chk("drop_first_gnt", 32'(req_ready), 32'(4'b0010));
        repeat (5) @(negedge clk);
        #1;
        chk("drop_gnt3", 32'(req_ready), 32'(4'b1000));
        @(negedge clk);
        req_valid = 4'b0010;
        repeat (3) @(negedge clk);
        #1;
        chk("drop_rsp", 32'({rsp_valid, rsp_err, rsp_id, rsp_data}), 32'({1'b1, 1'b0, 2'd3, 8'hD3}));
        @(negedge clk);
        #1;
        chk("drop_next_gnt", 32'(req_ready), 32'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
